// File: rtl/decoder_scan_sequencer.sv
// Scan sequencer feeding a 3-to-8 decoder: walks sel through a channel window,
// holding each channel for DWELL cycles, in one-shot or continuous mode.
module decoder_scan_sequencer #(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [2:0] cfg_first,
    input  logic [2:0] cfg_last,
    input  logic       cfg_cont,
    input  logic       start,
    input  logic       stop,
    output logic [2:0] sel,
    output logic       en,
    output logic       busy,
    output logic       done,
    output logic       wrap
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

    state_t           state_q, state_d;
    logic [2:0]       sel_q, sel_d;
    logic             en_q, en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             wrap_q, wrap_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       first_q, first_d;
    logic [2:0]       last_q, last_d;
    logic             cont_q, cont_d;

    assign cfg_ready = (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        en_d    = en_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        wrap_d  = 1'b0;
        cnt_d   = cnt_q;
        first_d = first_q;
        last_d  = last_q;
        cont_d  = cont_q;

        case (state_q)
            IDLE: begin
                en_d   = 1'b0;
                busy_d = 1'b0;
                cnt_d  = '0;
                if (cfg_valid) begin
                    first_d = cfg_first;
                    last_d  = cfg_last;
                    cont_d  = cfg_cont;
                end
                if (start && !stop) begin
                    // A config presented alongside start takes effect for this scan
                    sel_d   = cfg_valid ? cfg_first : first_q;
                    en_d    = 1'b1;
                    busy_d  = 1'b1;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (stop) begin
                    en_d    = 1'b0;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == DWELL_LAST) begin
                    cnt_d = '0;
                    if (sel_q != last_q) begin
                        sel_d = sel_q + 3'd1;
                    end else if (cont_q) begin
                        sel_d  = first_q;
                        wrap_d = 1'b1;
                    end else begin
                        en_d    = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                en_d    = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                en_d    = 1'b0;
                busy_d  = 1'b0;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 3'd0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
            cnt_q   <= '0;
            first_q <= 3'd0;
            last_q  <= 3'd7;
            cont_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            last_q  <= last_d;
            cont_q  <= cont_d;
        end
    end

    assign sel  = sel_q;
    assign en   = en_q;
    assign busy = busy_q;
    assign done = done_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Directed self-checking bench for decoder_scan_sequencer (DWELL=4).
module tb_decoder_scan_sequencer;

    localparam int DW = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [2:0] cfg_first = 3'd0;
    logic [2:0] cfg_last = 3'd0;
    logic       cfg_cont = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [2:0] sel;
    logic       en, busy, done, wrap;

    int checks = 0;
    int errors = 0;

    decoder_scan_sequencer #(.DWELL(DW), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_first(cfg_first), .cfg_last(cfg_last), .cfg_cont(cfg_cont),
        .start(start), .stop(stop),
        .sel(sel), .en(en), .busy(busy), .done(done), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input logic [2:0] f, input logic [2:0] l, input logic c);
        cfg_first = f;
        cfg_last  = l;
        cfg_cont  = c;
        cfg_valid = 1'b1;
    endtask

    // Call right after the start edge; walks nch channels and checks the DONE cycle.
    task automatic run_oneshot(input string name, input int first, input int nch);
        for (int i = 0; i < nch * DW; i++) begin
            chk($sformatf("%s_sel%0d", name, i), 8'(sel), 8'((first + i / DW) % 8));
            chk($sformatf("%s_en%0d", name, i), 8'(en), 8'd1);
            chk($sformatf("%s_busy%0d", name, i), 8'(busy), 8'd1);
            chk($sformatf("%s_done%0d", name, i), 8'(done), 8'd0);
            tick();
        end
        chk({name, "_done_en"}, 8'(en), 8'd0);
        chk({name, "_done_busy"}, 8'(busy), 8'd0);
        chk({name, "_done_pulse"}, 8'(done), 8'd1);
        chk({name, "_done_rdy"}, 8'(cfg_ready), 8'd0);
        tick();
        chk({name, "_post_done"}, 8'(done), 8'd0);
        chk({name, "_post_rdy"}, 8'(cfg_ready), 8'd1);
        $display("transaction %s: one-shot first=%0d channels=%0d checked", name, first, nch);
    endtask

    initial begin
        // Async reset with no clock edge involved
        #1 rst = 1'b1;
        #1;
        chk("rst_sel", 8'(sel), 8'd0);
        chk("rst_en", 8'(en), 8'd0);
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_done", 8'(done), 8'd0);
        chk("rst_wrap", 8'(wrap), 8'd0);
        chk("rst_rdy", 8'(cfg_ready), 8'd1);
        tick();
        rst = 1'b0;
        tick();
        $display("transaction reset: outputs checked");

        // One-shot, default window 0..7
        start = 1'b1;
        tick();
        start = 1'b0;
        run_oneshot("default", 0, 8);

        // Wrapping window 6..1
        set_cfg(3'd6, 3'd1, 1'b0);
        chk("cfg61_rdy", 8'(cfg_ready), 8'd1);
        tick();
        cfg_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_oneshot("win61", 6, 4);

        // Continuous 2..3
        set_cfg(3'd2, 3'd3, 1'b1);
        tick();
        cfg_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2 * DW; i++) begin
            chk($sformatf("cont_sel%0d", i), 8'(sel), 8'(2 + i / DW));
            chk($sformatf("cont_wrap%0d", i), 8'(wrap), 8'd0);
            chk($sformatf("cont_done%0d", i), 8'(done), 8'd0);
            if (i == 2) begin
                // Config offered mid-scan must be refused
                chk("scan_rdy", 8'(cfg_ready), 8'd0);
                set_cfg(3'd5, 3'd7, 1'b0);
            end
            tick();
            cfg_valid = 1'b0;
        end
        chk("cont_back_sel", 8'(sel), 8'd2);
        chk("cont_wrap_pulse", 8'(wrap), 8'd1);
        chk("cont_back_en", 8'(en), 8'd1);
        tick();
        chk("cont_wrap_drop", 8'(wrap), 8'd0);
        chk("cont_sel_hold", 8'(sel), 8'd2);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("cont_stop_en", 8'(en), 8'd0);
        chk("cont_stop_busy", 8'(busy), 8'd0);
        chk("cont_stop_done", 8'(done), 8'd0);
        chk("cont_stop_rdy", 8'(cfg_ready), 8'd1);
        $display("transaction continuous: window 2..3 with wrap and stop checked");

        // Mid-scan config was not captured: restart begins at 2 again
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("nocap_sel", 8'(sel), 8'd2);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("nocap_stop_en", 8'(en), 8'd0);
        $display("transaction nocapture: scan restarted at channel 2");

        // Stop on 3rd dwell cycle of channel 5
        set_cfg(3'd4, 3'd6, 1'b0);
        tick();
        cfg_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < DW + 2; i++) tick();
        chk("stop5_sel", 8'(sel), 8'd5);
        chk("stop5_en_before", 8'(en), 8'd1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop5_en", 8'(en), 8'd0);
        chk("stop5_busy", 8'(busy), 8'd0);
        chk("stop5_done", 8'(done), 8'd0);
        chk("stop5_wrap", 8'(wrap), 8'd0);
        chk("stop5_rdy", 8'(cfg_ready), 8'd1);
        tick();
        chk("stop5_done_later", 8'(done), 8'd0);
        $display("transaction stop: abort on channel 5 checked");

        // start+stop together in IDLE
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        chk("startstop_busy", 8'(busy), 8'd0);
        chk("startstop_en", 8'(en), 8'd0);
        tick();
        chk("startstop_busy2", 8'(busy), 8'd0);
        $display("transaction start_stop: no scan started");

        // Config and start in the same cycle
        set_cfg(3'd4, 3'd4, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        cfg_valid = 1'b0;
        run_oneshot("bypass44", 4, 1);

        // Async reset between edges mid-scan
        set_cfg(3'd3, 3'd5, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        cfg_valid = 1'b0;
        tick();
        tick();
        chk("prerst_sel", 8'(sel), 8'd3);
        #2 rst = 1'b1;
        #1;
        chk("midrst_sel", 8'(sel), 8'd0);
        chk("midrst_en", 8'(en), 8'd0);
        chk("midrst_busy", 8'(busy), 8'd0);
        chk("midrst_rdy", 8'(cfg_ready), 8'd1);
        #1 rst = 1'b0;
        tick();
        $display("transaction async_reset: outputs cleared between edges");
        start = 1'b1;
        tick();
        start = 1'b0;
        run_oneshot("after_rst", 0, 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time limit so the bench always ends
    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
